// File: rtl/hnoc_pkg.sv
// Shared HNoC definitions: flit and grant-id widths plus the rotate-priority search helper.
package hnoc_pkg;

  localparam int unsigned HNOC_FLIT_W  = 32;
  localparam int unsigned HNOC_REQ_IDW = 3;
  localparam int unsigned HNOC_MAX_REQ = 8;
  localparam int unsigned HNOC_BCNT_W  = 4;
  localparam int unsigned HNOC_CNT_W   = 32;
  localparam int unsigned HNOC_SUM_W   = HNOC_REQ_IDW + 1;

  typedef logic [HNOC_SUM_W-1:0] rr_sum_t;

  typedef struct packed {
    logic                    found;
    logic [HNOC_REQ_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid_vec searching ptr, ptr+1, ... modulo num_req.
  function automatic rr_pick_t rr_next(input logic [HNOC_REQ_IDW-1:0] ptr,
                                       input logic [HNOC_MAX_REQ-1:0] valid_vec,
                                       input int unsigned             num_req);
    rr_pick_t res;
    rr_sum_t  k;
    res = '0;
    for (int unsigned i = 0; i < HNOC_MAX_REQ; i++) begin
      k = {1'b0, ptr} + rr_sum_t'(i);
      if (k >= rr_sum_t'(num_req)) k = k - rr_sum_t'(num_req);
      if ((i < num_req) && !res.found && valid_vec[k[HNOC_REQ_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[HNOC_REQ_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: picks the first valid requester at or after ptr.
module rr_pick
  import hnoc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]      valid,
  input  logic [HNOC_REQ_IDW-1:0] ptr,
  output logic [HNOC_REQ_IDW-1:0] idx_c,
  output logic                    found_c
);

  logic [HNOC_MAX_REQ-1:0] valid_ext;
  rr_pick_t                pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    pick                   = rr_next(ptr, valid_ext, NUM_REQ);
  end

  assign idx_c   = pick.idx;
  assign found_c = pick.found;

endmodule

// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one NoC injection port through a
// single registered output stage; also counts flits accepted by the NoC.
module noc_inject_arbiter
  import hnoc_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = HNOC_FLIT_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_noc_data,
  output logic                      o_noc_valid,
  input  logic                      i_noc_ready,
  output logic [HNOC_REQ_IDW-1:0]   o_grant_id,
  input  logic                      i_count_clr,
  output logic [HNOC_CNT_W-1:0]     o_sent_count
);

  localparam int unsigned IDW   = HNOC_REQ_IDW;
  localparam int unsigned BCW   = HNOC_BCNT_W;
  localparam int unsigned CNT_W = HNOC_CNT_W;

  if (NUM_REQ < 2 || NUM_REQ > HNOC_MAX_REQ) begin : g_bad_num_req
    $error("noc_inject_arbiter: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("noc_inject_arbiter: MAX_BURST out of range");
  end

  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    last_q;
  logic [BCW-1:0]    bcnt_q;
  logic [IDW-1:0]    win_c;
  logic              found_c;
  logic              drain_c;
  logic              can_load_c;
  logic              accept_c;
  logic [BCW-1:0]    run_c;
  logic [IDW-1:0]    ptr_next_c;
  logic [DATA_W-1:0] win_data_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid   (i_req_valid),
    .ptr     (ptr_q),
    .idx_c   (win_c),
    .found_c (found_c)
  );

  // Handshake, winner data mux and burst bookkeeping for this cycle.
  always_comb begin
    drain_c     = o_noc_valid & i_noc_ready;
    can_load_c  = ~o_noc_valid | i_noc_ready;
    accept_c    = i_reset_n & found_c & can_load_c;
    o_req_ready = '0;
    win_data_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_c == IDW'(k)) begin
        o_req_ready[k] = accept_c;
        win_data_c     = i_req_data[k*DATA_W +: DATA_W];
      end
    end
    run_c      = (win_c == last_q) ? (bcnt_q + BCW'(1)) : BCW'(1);
    ptr_next_c = (win_c == IDW'(NUM_REQ - 1)) ? '0 : (win_c + IDW'(1));
  end

  // Output register: loads on accept, empties on a drain with no replacement.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_noc_valid <= 1'b0;
      o_noc_data  <= '0;
      o_grant_id  <= '0;
    end else if (accept_c) begin
      o_noc_valid <= 1'b1;
      o_noc_data  <= win_data_c;
      o_grant_id  <= win_c;
    end else if (drain_c) begin
      o_noc_valid <= 1'b0;
    end
  end

  // Burst fairness: a requester keeps priority until it has won MAX_BURST times in a row.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q  <= '0;
      last_q <= '0;
      bcnt_q <= '0;
    end else if (accept_c) begin
      last_q <= win_c;
      if (run_c >= BCW'(MAX_BURST)) begin
        ptr_q  <= ptr_next_c;
        bcnt_q <= '0;
      end else begin
        ptr_q  <= win_c;
        bcnt_q <= run_c;
      end
    end
  end

  // Drained-flit counter; a clear in the same cycle as a drain wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sent_count <= '0;
    end else if (i_count_clr) begin
      o_sent_count <= '0;
    end else if (drain_c) begin
      o_sent_count <= o_sent_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: cycle model plus per-source scoreboard, with directed
// fairness/backpressure/clear scenarios and a random soak.
module tb_noc_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    noc_data;
  logic             noc_valid;
  logic             noc_ready;
  logic [2:0]       grant_id;
  logic             count_clr;
  logic [31:0]      sent_count;

  logic [NR*DW-1:0] rr_data;
  logic [NR-1:0]    rr_valid;
  logic [NR-1:0]    rr_ready;
  logic [DW-1:0]    rr_noc_data;
  logic             rr_noc_valid;
  logic             rr_noc_ready;
  logic [2:0]       rr_grant_id;
  logic             rr_clr;
  logic [31:0]      rr_sent_count;

  noc_inject_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_data(req_data), .i_req_valid(req_valid),
    .o_req_ready(req_ready), .o_noc_data(noc_data), .o_noc_valid(noc_valid),
    .i_noc_ready(noc_ready), .o_grant_id(grant_id), .i_count_clr(count_clr),
    .o_sent_count(sent_count)
  );

  noc_inject_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(1)) dut_rr (
    .i_clk(clk), .i_reset_n(rst_n), .i_req_data(rr_data), .i_req_valid(rr_valid),
    .o_req_ready(rr_ready), .o_noc_data(rr_noc_data), .o_noc_valid(rr_noc_valid),
    .i_noc_ready(rr_noc_ready), .o_grant_id(rr_grant_id), .i_count_clr(rr_clr),
    .o_sent_count(rr_sent_count)
  );

  // Requester k presents {k, next sequence number}.
  logic [23:0] seq     [NR];
  logic [23:0] exp_seq [NR];
  always_comb begin
    for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = {8'(k), seq[k]};
  end

  int errors = 0;
  int checks = 0;

  // Model state: what the NoC-side register and arbiter must hold after each edge.
  bit          m_valid;
  logic [31:0] m_data;
  int          m_gid, m_ptr, m_last, m_bcnt;
  logic [31:0] m_cnt;
  logic [NR-1:0] acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int w, n, src;
    bit found, drain, can_load;
    logic [NR-1:0] er;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_gid = 0; m_ptr = 0; m_last = 0; m_bcnt = 0; m_cnt = '0;
      acc = '0;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", noc_valid, 0);
      chk("rst_data", noc_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_count", sent_count, 0);
      return;
    end
    found = 0; w = 0;
    for (int i = 0; i < NR; i++) begin
      if (!found && req_valid[(m_ptr + i) % NR]) begin
        found = 1;
        w = (m_ptr + i) % NR;
      end
    end
    drain    = m_valid && noc_ready;
    can_load = !m_valid || drain;
    er = '0;
    if (found && can_load) er[w] = 1'b1;
    chk("ready", req_ready, er);
    chk("valid", noc_valid, m_valid);
    if (m_valid) begin
      chk("data", noc_data, m_data);
      chk("gid", grant_id, m_gid);
    end
    chk("count", sent_count, m_cnt);
    chk("rr_skip", rr_ready & 4'b0101, 0);
    if (drain) begin
      src = int'(noc_data[31:24]);
      chk("sb_src", src, m_gid);
      if (src < NR) begin
        chk("sb_seq", noc_data[23:0], exp_seq[src]);
        exp_seq[src] = exp_seq[src] + 24'd1;
      end
    end
    acc = req_valid & req_ready;
    if (count_clr) m_cnt = '0;
    else if (drain) m_cnt = m_cnt + 32'd1;
    if (found && can_load) begin
      n = (w == m_last) ? m_bcnt + 1 : 1;
      m_data  = req_data[w*DW +: DW];
      m_gid   = w;
      m_valid = 1;
      if (n >= MB) begin m_ptr = (w + 1) % NR; m_bcnt = 0; end
      else begin m_ptr = w; m_bcnt = n; end
      m_last = w;
    end else if (drain) begin
      m_valid = 0;
    end
  endtask

  // One clock: compare/advance model at the falling edge, retire accepted flits after the rise.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) if (acc[k]) seq[k] = seq[k] + 24'd1;
  endtask

  int fair_exp [16] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3};
  logic [31:0] held;
  int n_soak;

  initial begin
    for (int k = 0; k < NR; k++) begin seq[k] = '0; exp_seq[k] = '0; end
    m_valid = 0; m_data = '0; m_gid = 0; m_ptr = 0; m_last = 0; m_bcnt = 0; m_cnt = '0;
    acc = '0;
    rst_n = 0; req_valid = 4'hF; noc_ready = 1; count_clr = 0;
    rr_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    rr_valid = 4'b1010; rr_noc_ready = 1; rr_clr = 0;

    repeat (3) tick();
    rst_n = 1;
    #1;
    chk("rel_ready", req_ready, 4'b0001);
    chk("rel_valid", noc_valid, 0);

    // Burst fairness with all requesters active; pure RR instance runs alongside.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("fair_valid", noc_valid, 1);
      chk("fair_gid", grant_id, fair_exp[i]);
      if (i < 8) chk("rr_gid", rr_grant_id, (i % 2) ? 3 : 1);
    end
    tick();
    chk("fair_count", sent_count, 16);
    chk("fair_wrap_gid", grant_id, 0);

    // Backpressure with a flit held.
    noc_ready = 0;
    held = m_data;
    repeat (5) begin
      tick();
      chk("bp_valid", noc_valid, 1);
      chk("bp_data", noc_data, held);
      chk("bp_ready", req_ready, 0);
      chk("bp_count", sent_count, 16);
    end
    noc_ready = 1;
    repeat (20) tick();

    // Clear colliding with a drain.
    count_clr = 1;
    tick();
    chk("clr_zero", sent_count, 0);
    count_clr = 0;
    tick();
    chk("clr_one", sent_count, 1);

    // Random soak up to exactly 1600 drained flits.
    noc_ready = 0;
    count_clr = 1;
    tick();
    count_clr = 0;
    chk("soak_start", sent_count, 0);
    n_soak = 0;
    while (m_cnt != 32'd1600 && n_soak < 20000) begin
      req_valid = 4'($urandom);
      noc_ready = 1'($urandom_range(0, 1));
      tick();
      n_soak++;
    end
    noc_ready = 0;
    req_valid = '0;
    chk("soak_bound", (n_soak < 20000), 1);
    repeat (2) tick();
    chk("soak_count", sent_count, 1600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_inject_arbiter.md
# noc_inject_arbiter

Round-robin arbiter sharing one HNoC PE injection port (32-bit valid/ready) among `NUM_REQ` local requesters. It sits between a cluster of PEs or traffic sources and a single `i_pe_dataN` / `i_pe_data_validN` / `o_pe_data_readyN` port. It uses a one-entry registered output stage and bounded burst fairness. It also keeps a count of injected flits for end-of-test detection.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 32: flit width.
- `MAX_BURST`, default 4: maximum consecutive grants to one requester before priority rotates, 1..15. A value of 1 gives pure round-robin.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_reset_n`  in  1  reset; asynchronous assert, active-low.
- `i_req_data`  in  NUM_REQ*DATA_W  requester flits; requester k occupies bits [k*DATA_W +: DATA_W].
- `i_req_valid`  in  NUM_REQ  per-requester valid.
- `o_req_ready`  out  NUM_REQ  per-requester ready; one-hot or zero.
- `o_noc_data`  out  DATA_W  flit to NoC port.
- `o_noc_valid`  out  1  flit valid to NoC.
- `i_noc_ready`  in  1  NoC port ready.
- `o_grant_id`  out  3  index of the requester whose flit is in the output register.
- `i_count_clr`  in  1  synchronous clear of `o_sent_count`.
- `o_sent_count`  out  32  flits accepted by the NoC; wraps modulo 2^32.

## Operation
- The output register is empty or full. Let `drain = o_noc_valid & i_noc_ready`. Let `can_load = !o_noc_valid | drain`.
- Arbitration is combinational each cycle. The winner `w` is the first k with `i_req_valid[k]=1`, searching k = ptr, ptr+1, … modulo NUM_REQ. The pointer `ptr` is registered.
- `o_req_ready[w] = can_load` when a winner exists. All other ready bits are 0. Ready never depends on the requester's own valid except through winner selection.
- Accept = `i_req_valid[w] & o_req_ready[w]`. On accept, the register loads `i_req_data[w]`, `o_noc_valid` goes to 1, and `o_grant_id` becomes w.
- On drain without accept, `o_noc_valid` goes to 0. Data and grant id hold their last values.
- Burst fairness uses two registers: `last` (previous winner) and `bcnt` (4 bits). On accept of w:
  - n = (w==last) ? bcnt+1 : 1.
  - If n ≥ MAX_BURST: ptr = (w+1) mod NUM_REQ, bcnt = 0.
  - Otherwise: ptr = w, bcnt = n.
  - In both cases, last = w.
- Without an accept, ptr, bcnt and last hold.
- Counter: `o_sent_count` increments on drain. If `i_count_clr` is 1 in the same cycle, the clear wins and the result is 0 (the drained flit is not counted).
- Stored flits are never dropped or reordered. A requester's flits leave in its own order.

## Timing
- Reset values: `o_noc_valid=0`, `o_noc_data=0`, `o_grant_id=0`, `o_req_ready=0`, `o_sent_count=0`, ptr=0, last=0, bcnt=0.
- Reset mid-operation clears the output register. A held flit is lost, which is acceptable by design.
- Latency: a flit accepted at edge t appears on `o_noc_valid` and `o_noc_data` after edge t and can drain at edge t+1.
- Full throughput: one flit per cycle while `i_noc_ready=1`, with back-to-back accept and drain in the same cycle.
- Backpressure: while `o_noc_valid=1` and `i_noc_ready=0`, all `o_req_ready` are 0. `o_noc_data` and `o_noc_valid` are stable until drain.
- `o_noc_valid`, once asserted, does not drop without a drain.
- No combinational path from `i_noc_ready` to `o_noc_valid` or `o_noc_data`. A combinational path from `i_noc_ready` to `o_req_ready` is allowed and expected.
- Edge cases:
  - No valid requester: no accept, state holds.
  - Single active requester: always wins. Its bcnt cycles through 1..MAX_BURST-1 and then 0; ptr rotates past it, but the search wraps back to it.

## Structure
- Shared package `hnoc_pkg` holds:
  - constant `HNOC_FLIT_W = 32`;
  - the grant-id width (`HNOC_REQ_IDW = 3`);
  - a function `rr_next(ptr, valid_vec)` returning the winner index and a found flag.
- One sub-module is natural: `rr_pick`, a combinational rotate-priority encoder taking `NUM_REQ` valids and the pointer and returning the winner index and found flag.
- The top level holds the output register, ptr/bcnt/last state and the counter.

## Test plan
- Reset: hold `i_reset_n=0` with all valids high. Require all `o_req_ready=0`, `o_noc_valid=0`, `o_sent_count=0`. Release reset: first accept is from requester 0, and `o_noc_valid=1` one edge later.
- Fairness, MAX_BURST=4: requesters 0..3 always valid, `i_noc_ready=1`. The `o_grant_id` sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; after 16 cycles `o_sent_count=16`.
- Pure round-robin, MAX_BURST=1: requesters 1 and 3 valid. Grants alternate 1,3,1,3; requesters 0 and 2 never get ready.
- Backpressure: `i_noc_ready=0` for 5 cycles with a flit held. `o_noc_data` is stable, all readies are 0, and the count does not change. Raise ready: flits drain in order with none lost or duplicated; each requester's data sequence is verified by a scoreboard.
- Clear collision: assert `i_count_clr` in the same cycle as a drain. Count reads 0 the next cycle, then 1 after the next drain.
- Soak, mirroring the 4-PE system check: random valids and random `i_noc_ready` for 1600 flits. The scoreboard verifies per-source order, and `o_sent_count=1600`.
